// File: rtl/agp32_mem_ctrl.sv
// Processor-side memory controller: sequences init, fetch/read/write to a single-port
// variable-latency memory, one-cycle interrupt handshake, and sticky timeout/alignment errors.
module agp32_mem_ctrl #(
   parameter int INIT_CYCLES = 4,
   parameter int TIMEOUT     = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  command,
   input  logic [31:0] PC,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic [3:0]  data_wstrb,
   output logic        ready,
   output logic [31:0] inst_rdata,
   output logic [31:0] data_rdata,
   output logic        mem_start_ready,
   output logic [1:0]  error,
   output logic        mem_req,
   output logic        mem_we,
   output logic [29:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [2:0] {
      S_INIT = 3'd0,
      S_IDLE = 3'd1,
      S_REQ  = 3'd2,
      S_INTR = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   localparam logic [7:0] INIT_LAST = 8'(INIT_CYCLES - 1);
   localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

   localparam logic [2:0] CMD_FETCH = 3'd1;
   localparam logic [2:0] CMD_READ  = 3'd2;
   localparam logic [2:0] CMD_WRITE = 3'd3;
   localparam logic [2:0] CMD_INTR  = 3'd4;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_init_cnt;
   logic [7:0]  r_to_cnt;
   logic        r_start_ready;
   logic [1:0]  r_error;
   logic        r_op_fetch;
   logic        r_op_read;
   logic        r_mem_we;
   logic [29:0] r_mem_addr;
   logic [3:0]  r_mem_be;
   logic [31:0] r_mem_wdata;
   logic [31:0] r_inst_rdata;
   logic [31:0] r_data_rdata;
   logic        w_ready;
   logic        w_mem_req;
   logic        w_accept;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_INIT;
      else     r_state <= w_state_nxt;
   end

   // Commands are only taken once mem_start_ready is up, so ready and sampling start together.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_INIT: if (r_init_cnt == INIT_LAST) w_state_nxt = S_IDLE;
         S_IDLE: begin
            if (r_start_ready) begin
               case (command)
                  CMD_FETCH: w_state_nxt = (PC[1:0] != 2'b00) ? S_ERR : S_REQ;
                  CMD_READ,
                  CMD_WRITE: w_state_nxt = S_REQ;
                  CMD_INTR:  w_state_nxt = S_INTR;
                  default:   w_state_nxt = S_IDLE;
               endcase
            end
         end
         S_REQ: begin
            if (mem_ack)                 w_state_nxt = S_IDLE;
            else if (r_to_cnt == TO_LAST) w_state_nxt = S_ERR;
         end
         S_INTR:  w_state_nxt = S_IDLE;
         S_ERR:   w_state_nxt = S_ERR;
         default: w_state_nxt = S_INIT;
      endcase
   end

   always_comb begin
      w_ready   = 1'b0;
      w_mem_req = 1'b0;
      case (r_state)
         S_IDLE:  w_ready   = r_start_ready;
         S_REQ:   w_mem_req = 1'b1;
         default: begin
            w_ready   = 1'b0;
            w_mem_req = 1'b0;
         end
      endcase
   end

   assign w_accept = (r_state == S_IDLE) && (w_state_nxt == S_REQ);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_init_cnt    <= 8'd0;
         r_to_cnt      <= 8'd0;
         r_start_ready <= 1'b0;
         r_error       <= 2'd0;
         r_op_fetch    <= 1'b0;
         r_op_read     <= 1'b0;
         r_mem_we      <= 1'b0;
         r_mem_addr    <= 30'd0;
         r_mem_be      <= 4'd0;
         r_mem_wdata   <= 32'd0;
         r_inst_rdata  <= 32'h0000_003F;
         r_data_rdata  <= 32'd0;
      end else begin
         if (r_state == S_INIT) r_init_cnt <= r_init_cnt + 8'd1;
         if (r_state == S_IDLE) r_start_ready <= 1'b1;

         if (w_accept) begin
            r_to_cnt    <= 8'd0;
            r_op_fetch  <= (command == CMD_FETCH);
            r_op_read   <= (command == CMD_READ);
            r_mem_we    <= (command == CMD_WRITE);
            r_mem_addr  <= (command == CMD_FETCH) ? PC[31:2] : data_addr[31:2];
            r_mem_be    <= (command == CMD_WRITE) ? data_wstrb : 4'hF;
            r_mem_wdata <= data_wdata;
         end

         if (r_state == S_REQ) begin
            if (mem_ack) begin
               if (r_op_fetch) r_inst_rdata <= mem_rdata;
               if (r_op_read)  r_data_rdata <= mem_rdata;
            end else begin
               r_to_cnt <= r_to_cnt + 8'd1;
            end
         end

         if ((r_state == S_IDLE) && (w_state_nxt == S_ERR)) r_error <= 2'd2;
         if ((r_state == S_REQ)  && (w_state_nxt == S_ERR)) r_error <= 2'd1;
      end
   end

   assign ready           = w_ready;
   assign mem_req         = w_mem_req;
   assign mem_start_ready = r_start_ready;
   assign error           = r_error;
   assign mem_we          = r_mem_we;
   assign mem_addr        = r_mem_addr;
   assign mem_be          = r_mem_be;
   assign mem_wdata       = r_mem_wdata;
   assign inst_rdata      = r_inst_rdata;
   assign data_rdata      = r_data_rdata;

endmodule

// File: tb/tb_agp32_mem_ctrl.sv
// Directed bench for agp32_mem_ctrl: init, fetch, byte write, read, interrupt, timeout,
// misaligned fetch and reset during an access.
module tb_agp32_mem_ctrl;

   logic        clk;
   logic        rst;
   logic [2:0]  command;
   logic [31:0] PC;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [3:0]  data_wstrb;
   logic        ready;
   logic [31:0] inst_rdata;
   logic [31:0] data_rdata;
   logic        mem_start_ready;
   logic [1:0]  error;
   logic        mem_req;
   logic        mem_we;
   logic [29:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   int n_total = 0;
   int n_pass  = 0;

   agp32_mem_ctrl #(.INIT_CYCLES(4), .TIMEOUT(255)) dut (
      .clk(clk), .rst(rst), .command(command), .PC(PC),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
      .ready(ready), .inst_rdata(inst_rdata), .data_rdata(data_rdata),
      .mem_start_ready(mem_start_ready), .error(error),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   initial begin
      int bad;
      rst = 1'b1; command = 3'd0; PC = 32'd0; data_addr = 32'd0;
      data_wdata = 32'd0; data_wstrb = 4'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
      tick();
      rst = 1'b0;
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_msr", 32'(mem_start_ready), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_inst", inst_rdata, 32'h3F);
      chk("rst_data", data_rdata, 32'd0);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_be", 32'(mem_be), 32'd0);

      // Init: mem_start_ready and ready rise on the 5th edge after the reset edge.
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk($sformatf("init_msr_e%0d", i), 32'(mem_start_ready), 32'd0);
      end
      chk("init_ready_e4", 32'(ready), 32'd0);
      tick();
      chk("init_msr_e5", 32'(mem_start_ready), 32'd1);
      chk("init_ready_e5", 32'(ready), 32'd1);
      chk("init_error", 32'(error), 32'd0);

      // Fetch with ack in the first REQ cycle.
      PC = 32'h100; command = 3'd1;
      tick();
      command = 3'd0;
      chk("fetch_ready_lo", 32'(ready), 32'd0);
      chk("fetch_req", 32'(mem_req), 32'd1);
      chk("fetch_addr", 32'(mem_addr), 32'h40);
      chk("fetch_we", 32'(mem_we), 32'd0);
      chk("fetch_be", 32'(mem_be), 32'hF);
      mem_ack = 1'b1; mem_rdata = 32'h12345678;
      tick();
      mem_ack = 1'b0;
      chk("fetch_ready_hi", 32'(ready), 32'd1);
      chk("fetch_inst", inst_rdata, 32'h12345678);
      chk("fetch_req_off", 32'(mem_req), 32'd0);
      chk("fetch_data_keep", data_rdata, 32'd0);

      // Byte write, ack in the third REQ cycle.
      data_addr = 32'h203; data_wstrb = 4'h8; data_wdata = 32'hAB000000; command = 3'd3;
      tick();
      command = 3'd0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("wr_req_c%0d", i), 32'(mem_req), 32'd1);
         chk($sformatf("wr_addr_c%0d", i), 32'(mem_addr), 32'h80);
         chk($sformatf("wr_be_c%0d", i), 32'(mem_be), 32'h8);
         chk($sformatf("wr_we_c%0d", i), 32'(mem_we), 32'd1);
         chk($sformatf("wr_wdata_c%0d", i), mem_wdata, 32'hAB000000);
         if (i == 2) begin
            mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
         end
         tick();
      end
      mem_ack = 1'b0;
      chk("wr_ready", 32'(ready), 32'd1);
      chk("wr_data_keep", data_rdata, 32'd0);
      chk("wr_inst_keep", inst_rdata, 32'h12345678);

      // Data read with immediate ack.
      data_addr = 32'h10; command = 3'd2;
      tick();
      command = 3'd0;
      chk("rd_addr", 32'(mem_addr), 32'h4);
      chk("rd_be", 32'(mem_be), 32'hF);
      mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
      tick();
      mem_ack = 1'b0;
      chk("rd_data", data_rdata, 32'hCAFEF00D);
      chk("rd_inst_keep", inst_rdata, 32'h12345678);

      // Interrupt handshake: ready low for exactly one cycle.
      command = 3'd4;
      tick();
      command = 3'd0;
      chk("intr_ready_lo", 32'(ready), 32'd0);
      chk("intr_req", 32'(mem_req), 32'd0);
      tick();
      chk("intr_ready_hi", 32'(ready), 32'd1);

      // Reserved command stays idle; a stray ack is ignored.
      command = 3'd5; mem_ack = 1'b1; mem_rdata = 32'h11111111;
      tick();
      command = 3'd0; mem_ack = 1'b0;
      chk("cmd5_ready", 32'(ready), 32'd1);
      chk("cmd5_req", 32'(mem_req), 32'd0);
      chk("stray_ack_data", data_rdata, 32'hCAFEF00D);

      // Timeout: 255 REQ cycles without ack.
      data_addr = 32'h40; command = 3'd2;
      tick();
      command = 3'd0;
      bad = 0;
      for (int i = 0; i < 254; i++) begin
         if (mem_req !== 1'b1 || error !== 2'd0) bad++;
         tick();
      end
      chk("to_hold", 32'(bad), 32'd0);
      chk("to_last_req", 32'(mem_req), 32'd1);
      tick();
      chk("to_error", 32'(error), 32'd1);
      chk("to_req_off", 32'(mem_req), 32'd0);
      chk("to_ready", 32'(ready), 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'h22222222;
      tick();
      mem_ack = 1'b0;
      chk("to_late_ack_err", 32'(error), 32'd1);
      chk("to_late_ack_data", data_rdata, 32'hCAFEF00D);
      chk("to_late_ready", 32'(ready), 32'd0);
      chk("to_msr_keep", 32'(mem_start_ready), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("to_rst_error", 32'(error), 32'd0);
      chk("to_rst_data", data_rdata, 32'd0);
      chk("to_rst_inst", inst_rdata, 32'h3F);
      repeat (5) tick();
      chk("to_reinit_ready", 32'(ready), 32'd1);

      // Misaligned fetch.
      PC = 32'h102; command = 3'd1;
      tick();
      command = 3'd0;
      chk("mis_error", 32'(error), 32'd2);
      chk("mis_req", 32'(mem_req), 32'd0);
      chk("mis_ready", 32'(ready), 32'd0);
      tick();
      chk("mis_error_hold", 32'(error), 32'd2);
      chk("mis_req_hold", 32'(mem_req), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (5) tick();
      chk("mis_reinit_ready", 32'(ready), 32'd1);

      // Reset during REQ with ack at the same edge: no capture.
      PC = 32'h200; command = 3'd1;
      tick();
      command = 3'd0;
      chk("rmid_req", 32'(mem_req), 32'd1);
      mem_ack = 1'b1; mem_rdata = 32'h55555555; rst = 1'b1;
      tick();
      rst = 1'b0; mem_ack = 1'b0;
      chk("rmid_inst", inst_rdata, 32'h3F);
      chk("rmid_req_off", 32'(mem_req), 32'd0);
      chk("rmid_msr", 32'(mem_start_ready), 32'd0);
      chk("rmid_ready", 32'(ready), 32'd0);
      chk("rmid_addr", 32'(mem_addr), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
